imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Sequences instruction-memory initialisation for the single-cycle MIPS core.
//  Accepts a stream of program words over valid/ready and writes them to the
//  instruction-memory write port at byte addresses 0,4,8,...
//  Holds the core in reset until loading completes, then releases it and
//  hands the fetch address (imem_a) over to the core PC.
// PARAMETERS
//  IMEM_DEPTH  1000  instruction-memory depth in 32-bit words
//  LEN_W       10    width of the word-count input
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      1-cycle pulse: begin load of len words
//  len        in   LEN_W  number of program words; sampled when start is high
//  s_valid    in   1      stream word valid
//  s_data     in   32     stream word
//  s_ready    out  1      loader can accept s_data
//  cpu_pc     in   32     core PC (byte address)
//  imem_a     out  32     instruction-memory address: cpu_pc when running, else wr_addr
//  wr_en      out  1      instruction-memory write enable
//  wr_addr    out  32     write byte address (word index << 2)
//  wr_data    out  32     write data
//  cpu_rst_n  out  1      core reset, active-low; 0 until load done
//  busy       out  1      load in progress
//  done       out  1      program loaded, core running
//  err        out  1      load rejected or failed; sticky until next start
// BEHAVIOUR
//  - Reset values: state IDLE; s_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_rst_n=0,
//    busy=0, done=0, err=0, word counter=0.
//  - States: IDLE, LOAD, RUN, and CHECK (CHECK exists only with the checksum feature).
//  - IDLE, start=1:
//    - len==0 or len>IMEM_DEPTH: err=1; remain IDLE; no writes.
//    - Otherwise: latch len; counter=0; clear err; go to LOAD next cycle.
//  - LOAD:
//    - s_ready=1 and busy=1.
//    - A beat transfers when s_valid&&s_ready.
//    - One cycle after a beat: wr_en=1, wr_addr=cnt<<2, wr_data=beat data.
//      wr_en is a 1-cycle pulse per beat. Back-to-back beats give back-to-back writes.
//    - When the beat with cnt==len-1 transfers, s_ready drops the next cycle.
//    - Without checksum: go to RUN.
//    - start is ignored while in LOAD.
//  - RUN:
//    - cpu_rst_n=1 and done=1, both asserted in the same cycle as the final wr_en pulse.
//    - imem_a=cpu_pc. In all other states imem_a=wr_addr.
//    - start=1 re-enters the start path exactly as from IDLE; on a valid len it
//      drives cpu_rst_n=0 and done=0 the next cycle.
//    - A start with invalid len in RUN: set err=1, keep running.
//  - Counter is LEN_W+1 bits wide, so there is no wrap for len==IMEM_DEPTH.
//    Write address is the zero-extended cnt<<2.
//  - rst_n asserted mid-load: immediate return to reset values.
//    Memory contents already written are left as-is; core stays in reset.
// CONFIGURATION
//  IMEM_BOOT_CHECKSUM_EN:
//  - Defined: an XOR accumulator over all len data words, cleared on start.
//    After the last data beat go to CHECK (s_ready=1).
//    - The next beat is the trailer. It is not written to memory.
//    - Trailer == accumulator: go to RUN.
//    - Trailer != accumulator: err=1 and go to IDLE; core stays in reset.
//  - Undefined: no CHECK state, no accumulator, no trailer beat.
//    err is raised only for invalid len.
// STRUCTURE
//  - Shared package mips_pkg holds:
//    - IMEM_DEPTH_WORDS constant (1000), shared with the instruction memory
//    - boot_state_t encoding: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, CHECK=2'd3
//    - WORD_W=32
//  - No sub-module. The XOR accumulator is a handful of lines kept inline
//    under the macro.
// TESTING
//  1. Reset, start with len=3, stream 0x20080005, 0x20090007, 0x01095020 with no gaps
//     -> wr_en pulses at addr 0x0, 0x4, 0x8.
//     -> cpu_rst_n=1 and done=1 in the cycle of the third write.
//     -> imem_a follows cpu_pc afterwards.
//  2. len=2 with s_valid toggling 1,0,0,1
//     -> exactly 2 writes (addr 0x0, 0x4), each 1 cycle after its handshake.
//     -> s_ready=0 after the second beat.
//  3. start with len=0, then start with len=1001
//     -> err=1 both times; state IDLE; no wr_en; cpu_rst_n stays 0.
//  4. rst_n low after 2 of 4 beats
//     -> all outputs at reset values asynchronously.
//     -> a new start with len=4 then completes normally from addr 0x0.
//  5. In RUN, start with len=1, data 0xDEADBEEF
//     -> cpu_rst_n=0 next cycle; write at 0x0; core released again.
//  6. (IMEM_BOOT_CHECKSUM_EN) len=2 with data 0x1 and 0x3:
//     -> trailer 0x2: RUN, err=0.
//     -> trailer 0x5: err=1, state IDLE, cpu_rst_n=0.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Purpose : Definitions shared by the single-cycle MIPS core and its
//           instruction-memory boot loader: memory depth, word width,
//           boot-loader state encoding and a length-validation helper.
// Ports   : none (package)
// Options : IMEM_BOOT_CHECKSUM_EN enables the CHECK state in the loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    // Instruction memory depth in 32-bit words; the memory and the loader
    // must agree on this value.
    localparam int IMEM_DEPTH_WORDS = 1000;
    localparam int WORD_W           = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        CHECK = 2'd3
    } boot_state_t;

    // A program length is usable when it is non-zero and fits in memory.
    function automatic logic len_is_valid(input int unsigned len,
                                          input int unsigned depth);
        return (len != 0) && (len <= depth);
    endfunction

endpackage : mips_pkg

`default_nettype wire

// File: rtl/imem_boot_loader_if.sv
// ============================================================================
// Module  : imem_boot_loader_if
// Purpose : Bundles the boot loader's control, program stream, memory write
//           port and core hand-off signals.
// Ports   : start/len    - load request and program length in words
//           s_valid/s_data/s_ready - program word stream
//           cpu_pc/imem_a - core PC in, instruction-memory address out
//           wr_en/wr_addr/wr_data - instruction-memory write port
//           cpu_rst_n/busy/done/err - core reset and loader status
//           Modport slave is the loader side, master the environment side.
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_boot_loader_if #(
    parameter int LEN_W = 10
);
    import mips_pkg::*;

    logic                 start;
    logic [LEN_W-1:0]     len;
    logic                 s_valid;
    logic [WORD_W-1:0]    s_data;
    logic                 s_ready;
    logic [WORD_W-1:0]    cpu_pc;
    logic [WORD_W-1:0]    imem_a;
    logic                 wr_en;
    logic [WORD_W-1:0]    wr_addr;
    logic [WORD_W-1:0]    wr_data;
    logic                 cpu_rst_n;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport slave (
        input  start, len, s_valid, s_data, cpu_pc,
        output s_ready, imem_a, wr_en, wr_addr, wr_data,
               cpu_rst_n, busy, done, err
    );

    modport master (
        output start, len, s_valid, s_data, cpu_pc,
        input  s_ready, imem_a, wr_en, wr_addr, wr_data,
               cpu_rst_n, busy, done, err
    );

endinterface : imem_boot_loader_if

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module  : imem_boot_loader
// Purpose : Loads a program into instruction memory from a valid/ready word
//           stream (byte addresses 0,4,8,...), holds the core in reset while
//           loading, then releases it and hands imem_a over to the core PC.
// Ports   : clk    - single clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - imem_boot_loader_if.slave (see interface header)
// Params  : IMEM_DEPTH - memory depth in words, LEN_W - width of len
// Options : IMEM_BOOT_CHECKSUM_EN - after the data words, one trailer word is
//           accepted and compared with the XOR of all data words; a mismatch
//           flags err and leaves the core in reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_WORDS,
    parameter int LEN_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_boot_loader_if.slave bus
);

    localparam logic [LEN_W:0] c_depth_words = (LEN_W+1)'(IMEM_DEPTH);
    localparam logic [LEN_W:0] c_one         = (LEN_W+1)'(1);

    boot_state_t        state_q,   state_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    // One bit wider than len so a full-depth load never wraps.
    logic [LEN_W:0]     cnt_q,     cnt_d;
    logic               err_q,     err_d;
    logic               wr_en_q,   wr_en_d;
    logic [WORD_W-1:0]  wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]  wr_data_q, wr_data_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [WORD_W-1:0]  acc_q,     acc_d;
`endif

    logic w_s_ready;
    logic w_beat;
    logic w_last;
    logic w_len_ok;

    // ------------------------------------------------------------------
    // Status outputs are pure decodes of the state, so cpu_rst_n/done rise
    // in the same cycle the final write pulse appears.
    // ------------------------------------------------------------------
`ifdef IMEM_BOOT_CHECKSUM_EN
    assign w_s_ready = (state_q == LOAD) || (state_q == CHECK);
`else
    assign w_s_ready = (state_q == LOAD);
`endif
    assign w_beat    = bus.s_valid && w_s_ready;
    assign w_last    = (cnt_q == ({1'b0, len_q} - c_one));
    assign w_len_ok  = len_is_valid(32'({1'b0, bus.len}), 32'(c_depth_words));

    assign bus.s_ready   = w_s_ready;
    assign bus.busy      = w_s_ready;
    assign bus.cpu_rst_n = (state_q == RUN);
    assign bus.done      = (state_q == RUN);
    assign bus.err       = err_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.imem_a    = (state_q == RUN) ? bus.cpu_pc : wr_addr_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
        acc_d     = acc_q;
`endif

        case (state_q)
            // A start from RUN behaves exactly like one from IDLE; a bad
            // length in RUN only flags err and leaves the core running.
            IDLE, RUN: begin
                if (bus.start) begin
                    if (w_len_ok) begin
                        len_d   = bus.len;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = LOAD;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        acc_d   = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            LOAD: begin
                if (w_beat) begin
                    // The write lands one cycle after its handshake.
                    wr_en_d   = 1'b1;
                    wr_addr_d = {{(WORD_W-LEN_W-3){1'b0}}, cnt_q, 2'b00};
                    wr_data_d = bus.s_data;
                    cnt_d     = cnt_q + c_one;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    acc_d     = acc_q ^ bus.s_data;
                    if (w_last) begin
                        state_d = CHECK;
                    end
`else
                    if (w_last) begin
                        state_d = RUN;
                    end
`endif
                end
            end

`ifdef IMEM_BOOT_CHECKSUM_EN
            // The trailer beat is compared, never written.
            CHECK: begin
                if (w_beat) begin
                    if (bus.s_data == acc_q) begin
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            acc_q     <= acc_d;
`endif
        end
    end

endmodule : imem_boot_loader

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module  : tb_imem_boot_loader
// Purpose : Self-checking bench for imem_boot_loader. Programs are random
//           word arrays; the expected memory image, write addresses, stream
//           handshakes and core hand-off timing are derived from the
//           program itself. A behavioural instruction memory captures writes.
// Options : IMEM_BOOT_CHECKSUM_EN - adds trailer handling and checksum cases.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;
    import mips_pkg::*;

    localparam int LEN_W = 10;
    localparam int DEPTH = IMEM_DEPTH_WORDS;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.LEN_W(LEN_W)) bus ();

    imem_boot_loader #(
        .IMEM_DEPTH (DEPTH),
        .LEN_W      (LEN_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_wr   = 0;

    logic [31:0] prog [0:1023];
    logic [31:0] imem [0:DEPTH-1];

    // Behavioural instruction memory.
    always @(posedge clk) begin
        if (bus.wr_en) begin
            n_wr <= n_wr + 1;
            if (bus.wr_addr[31:2] < 30'(DEPTH)) imem[bus.wr_addr[31:2]] <= bus.wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_s_ready",   32'(bus.s_ready),   32'd0);
        chk("rst_wr_en",     32'(bus.wr_en),     32'd0);
        chk("rst_wr_addr",   bus.wr_addr,        32'd0);
        chk("rst_wr_data",   bus.wr_data,        32'd0);
        chk("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
    endtask

    function automatic logic [31:0] xor_of(input int n);
        logic [31:0] x = 32'd0;
        for (int k = 0; k < n; k++) x ^= prog[k];
        return x;
    endfunction

    // Load prog[0..n-1]. Called at posedge+1. gap: percent of idle cycles
    // on s_valid, or -1 for the fixed pattern 1,0,0,1,...
    // bad_trl only matters with the checksum feature.
    task automatic load_prog(input int n, input int gap, input logic bad_trl);
        int          i        = 0;
        int          guard    = 0;
        logic        pend     = 1'b0;
        int          pend_idx = 0;
        int          wr0;
        logic        ok;
        for (int k = 0; k < n; k++) imem[k] = 32'hBAD0_0000 ^ 32'(k);
        wr0        = n_wr;
        bus.start  = 1'b1;
        bus.len    = n[LEN_W-1:0];
        @(posedge clk); #1;
        bus.start  = 1'b0;
        while (i < n && guard < 4000) begin
            bus.s_valid = (gap < 0) ? (guard % 3 == 0) : ($urandom_range(99) >= 32'(gap));
            bus.s_data  = prog[i];
            @(negedge clk);
            chk("load_s_ready",   32'(bus.s_ready),   32'd1);
            chk("load_busy",      32'(bus.busy),      32'd1);
            chk("load_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
            chk("load_wr_en",     32'(bus.wr_en),     32'(pend));
            if (pend) begin
                chk("load_wr_addr", bus.wr_addr, 32'(pend_idx) << 2);
                chk("load_wr_data", bus.wr_data, prog[pend_idx]);
            end
            @(posedge clk); #1;
            pend     = bus.s_valid;
            pend_idx = i;
            if (bus.s_valid) i++;
            guard++;
        end
        if (i < n) chk("load_timeout", 32'd0, 32'd1);
        bus.s_valid = 1'b0;
        ok = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
        guard = 0;
        begin
            logic trl_done = 1'b0;
            while (!trl_done && guard < 100) begin
                bus.s_valid = ($urandom_range(99) >= 32'(gap < 0 ? 30 : gap));
                bus.s_data  = bad_trl ? (xor_of(n) ^ 32'h0000_0007) : xor_of(n);
                @(negedge clk);
                chk("chk_s_ready",   32'(bus.s_ready),   32'd1);
                chk("chk_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
                chk("chk_wr_en",     32'(bus.wr_en),     32'(pend));
                if (pend) begin
                    chk("chk_wr_addr", bus.wr_addr, 32'(pend_idx) << 2);
                    chk("chk_wr_data", bus.wr_data, prog[pend_idx]);
                end
                @(posedge clk); #1;
                pend     = 1'b0;
                trl_done = bus.s_valid;
                guard++;
            end
            if (!trl_done) chk("trailer_timeout", 32'd0, 32'd1);
            bus.s_valid = 1'b0;
            @(negedge clk);
            chk("trl_wr_en",    32'(bus.wr_en),     32'd0);
            chk("trl_done",     32'(bus.done),      32'(!bad_trl));
            chk("trl_cpu_rstn", 32'(bus.cpu_rst_n), 32'(!bad_trl));
            chk("trl_err",      32'(bus.err),       32'(bad_trl));
            chk("trl_s_ready",  32'(bus.s_ready),   32'd0);
            ok = !bad_trl;
        end
`else
        @(negedge clk);
        chk("last_wr_en",     32'(bus.wr_en),     32'(pend));
        chk("last_wr_addr",   bus.wr_addr,        32'(n - 1) << 2);
        chk("last_wr_data",   bus.wr_data,        prog[n-1]);
        chk("last_done",      32'(bus.done),      32'd1);
        chk("last_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
        chk("last_s_ready",   32'(bus.s_ready),   32'd0);
        chk("last_busy",      32'(bus.busy),      32'd0);
        chk("last_err",       32'(bus.err),       32'd0);
`endif
        @(posedge clk); #1;
        chk("write_count", 32'(n_wr - wr0), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (imem[k] !== prog[k]) chk("imem_word", imem[k], prog[k]);
        end
        n_chk++;
        if (ok) begin
            bus.cpu_pc = $urandom & 32'hFFFF_FFFC;
            @(negedge clk);
            chk("run_imem_a", bus.imem_a, bus.cpu_pc);
            @(posedge clk); #1;
        end
    endtask

    // Rejected start: err set, nothing written, core state unchanged.
    task automatic bad_start(input int n, input logic running);
        int   wr0 = n_wr;
        logic [31:0] a0 = bus.wr_addr;
        bus.start = 1'b1;
        bus.len   = n[LEN_W-1:0];
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("bad_err",       32'(bus.err),       32'd1);
            chk("bad_busy",      32'(bus.busy),      32'd0);
            chk("bad_cpu_rst_n", 32'(bus.cpu_rst_n), 32'(running));
            chk("bad_done",      32'(bus.done),      32'(running));
            if (!running) chk("bad_imem_a", bus.imem_a, a0);
            @(posedge clk); #1;
        end
        chk("bad_no_write", 32'(n_wr - wr0), 32'd0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.len     = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.cpu_pc  = '0;
        #1 rst_n = 1'b0;
        #2 chk_reset_vals();
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed program, no gaps.
        prog[0] = 32'h2008_0005; prog[1] = 32'h2009_0007; prog[2] = 32'h0109_5020;
        load_prog(3, 0, 1'b0);

        // Gapped stream 1,0,0,1.
        prog[0] = $urandom; prog[1] = $urandom;
        load_prog(2, -1, 1'b0);

        // Invalid lengths while running keep the core running.
        bad_start(0, 1'b1);
        bad_start(DEPTH + 1, 1'b1);

        // Reset mid-load, then invalid lengths from IDLE.
        for (int k = 0; k < 4; k++) prog[k] = $urandom;
        bus.start = 1'b1; bus.len = 10'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = prog[0];
        @(posedge clk); #1;
        bus.s_data = prog[1];
        @(posedge clk); #2;
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        bad_start(0, 1'b0);
        bad_start(DEPTH + 1, 1'b0);
        load_prog(4, 0, 1'b0);

        // Reload from RUN with a single word.
        prog[0] = 32'hDEAD_BEEF;
        load_prog(1, 20, 1'b0);

        // Random programs with random gaps and random rejected lengths.
        for (int t = 0; t < 6; t++) begin
            int n = int'($urandom_range(1, 20));
            for (int k = 0; k < n; k++) prog[k] = $urandom;
            load_prog(n, int'($urandom_range(0, 60)), 1'b0);
            if (t % 2 == 1) bad_start(int'($urandom_range(DEPTH + 1, 1023)), 1'b1);
        end

        // Full-depth program: last address 0xF9C.
        for (int k = 0; k < DEPTH; k++) prog[k] = $urandom;
        load_prog(DEPTH, 0, 1'b0);

`ifdef IMEM_BOOT_CHECKSUM_EN
        prog[0] = 32'h1; prog[1] = 32'h3;
        load_prog(2, 0, 1'b0);
        load_prog(2, 0, 1'b1);
        @(negedge clk);
        chk("cks_fail_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_imem_boot_loader

`default_nettype wire
